// File: rtl/tile_array_ctrl_if.sv
// Scheduler-facing bundle of tile_array_ctrl.
// The master side (layer scheduler / staging buffers) drives i_* and the slave side (the controller) drives o_*.
// Handshake: the scheduler asserts i_start for one or more cycles.
// The controller accepts it only while idle, on the rising clk edge where it is sampled.
// It then reports progress through o_busy and ends the job with a single-cycle o_done.
// Optional macro TILE_CTRL_PERF_EN adds the o_cyc_cnt / o_stall_cnt counters.
interface tile_array_ctrl_if #(parameter int K_BW = 10);
  logic            i_start;
  logic [2:0]      i_layer;
  logic [K_BW-1:0] i_k_len;
  logic            i_stall;
  logic            o_rd_en;
  logic [K_BW-1:0] o_rd_addr;
  logic            o_en_tf;
  logic [1:0]      o_cal_state;
  logic [2:0]      o_layer_state;
  logic            o_busy;
  logic            o_acc_valid;
  logic            o_done;
`ifdef TILE_CTRL_PERF_EN
  logic [15:0]     o_cyc_cnt;
  logic [15:0]     o_stall_cnt;

  modport master (output i_start, i_layer, i_k_len, i_stall,
                  input  o_rd_en, o_rd_addr, o_en_tf, o_cal_state, o_layer_state,
                         o_busy, o_acc_valid, o_done, o_cyc_cnt, o_stall_cnt);
  modport slave  (input  i_start, i_layer, i_k_len, i_stall,
                  output o_rd_en, o_rd_addr, o_en_tf, o_cal_state, o_layer_state,
                         o_busy, o_acc_valid, o_done, o_cyc_cnt, o_stall_cnt);
`else
  modport master (output i_start, i_layer, i_k_len, i_stall,
                  input  o_rd_en, o_rd_addr, o_en_tf, o_cal_state, o_layer_state,
                         o_busy, o_acc_valid, o_done);
  modport slave  (input  i_start, i_layer, i_k_len, i_stall,
                  output o_rd_en, o_rd_addr, o_en_tf, o_cal_state, o_layer_state,
                         o_busy, o_acc_valid, o_done);
`endif
endinterface

// File: rtl/tile_array_ctrl.sv
// Sequencer for the T_ROWS x T_COLS tile array.
// Its work per job:
//   - clears the accumulators in LOAD;
//   - streams K buffer reads in CALC, honouring i_stall;
//   - flushes the skewed array for DRAIN_CYC cycles;
//   - pulses done / acc_valid.
// Optional macro TILE_CTRL_PERF_EN adds cycle and stall counters.
module tile_array_ctrl #(
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int T_ROWS = 5,
  parameter int T_COLS = 5,
  parameter int K_BW   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  tile_array_ctrl_if.slave  bus
);
  localparam int DRAIN_CYC = ROWS*T_ROWS + COLS*T_COLS - 2;
  localparam int DC_W      = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [2:0]      r_layer;
  logic [K_BW-1:0] r_k_len;
  logic [K_BW-1:0] r_rd_addr;
  logic            r_en_tf;
  logic [DC_W-1:0] r_drain_cnt;

  logic            w_accept;
  logic            w_at_last;
  logic            w_rd_en;
  logic            w_busy;
  logic            w_done;
  logic            w_acc_valid;
  logic [1:0]      w_cal_state;

  assign w_accept  = (r_state == S_IDLE) && bus.i_start;
  // The address doubles as the beat counter: it equals the number of beats already issued.
  assign w_at_last = (r_rd_addr == r_k_len - K_BW'(1));

  // State register; reset aborts any job without a completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and per-state outputs
  always_comb begin
    w_next      = r_state;
    w_cal_state = 2'b00;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_acc_valid = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_next = (bus.i_k_len == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        w_cal_state = 2'b01;
        w_busy      = 1'b1;
        w_next      = S_CALC;
      end
      S_CALC: begin
        w_cal_state = 2'b10;
        w_busy      = 1'b1;
        w_rd_en     = !bus.i_stall;
        if (!bus.i_stall && w_at_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_cal_state = 2'b11;
        w_busy      = 1'b1;
        if (r_drain_cnt == DC_W'(DRAIN_CYC - 1)) w_next = S_DONE;
      end
      S_DONE: begin
        w_cal_state = 2'b11;
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_acc_valid = (r_k_len != '0);
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Job registers: latched parameters, read address, transfer-enable delay, drain timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_layer     <= '0;
      r_k_len     <= '0;
      r_rd_addr   <= '0;
      r_en_tf     <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_layer <= bus.i_layer;
        r_k_len <= bus.i_k_len;
      end else if (r_state == S_DONE) begin
        r_layer <= '0;
      end
      // Buffer data lands one cycle after the strobe, so the array enable trails it by one.
      r_en_tf <= w_rd_en;
      if (w_rd_en && !w_at_last)  r_rd_addr <= r_rd_addr + K_BW'(1);
      else if (r_state == S_DONE) r_rd_addr <= '0;
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + DC_W'(1) : '0;
    end
  end

  assign bus.o_rd_en       = w_rd_en;
  assign bus.o_rd_addr     = r_rd_addr;
  assign bus.o_en_tf       = r_en_tf || (r_state == S_DRAIN);
  assign bus.o_cal_state   = w_cal_state;
  assign bus.o_layer_state = r_layer;
  assign bus.o_busy        = w_busy;
  assign bus.o_acc_valid   = w_acc_valid;
  assign bus.o_done        = w_done;

`ifdef TILE_CTRL_PERF_EN
  logic [15:0] r_cyc_cnt;
  logic [15:0] r_stall_cnt;

  // Saturating busy-cycle and CALC-stall counters, cleared when a job is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt   <= '0;
      r_stall_cnt <= '0;
    end else if (w_accept) begin
      r_cyc_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_busy && r_cyc_cnt != 16'hFFFF) r_cyc_cnt <= r_cyc_cnt + 16'd1;
      if (r_state == S_CALC && bus.i_stall && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.o_cyc_cnt   = r_cyc_cnt;
  assign bus.o_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_tile_array_ctrl.sv
// Bench for tile_array_ctrl.
// Runs a directed job schedule, covering:
//   - a basic run;
//   - a start while busy, followed by a back-to-back start;
//   - a zero-length job;
//   - a stalled job;
//   - a mid-CALC async reset.
// A job-level planner fills per-cycle expected-output tables, and every cycle is compared against them.
module tb_tile_array_ctrl;
  localparam int K_BW  = 10;
  localparam int DRAIN = 48;
  localparam int N     = 290;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  bit   running = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  tile_array_ctrl_if #(.K_BW(K_BW)) bus ();

  tile_array_ctrl #(.ROWS(5), .COLS(5), .T_ROWS(5), .T_COLS(5), .K_BW(K_BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // stimulus tables, indexed by cycle
  bit st_start[N];
  int st_layer[N];
  int st_klen[N];
  bit st_stall[N];

  // expected outputs, indexed by cycle
  int e_rd_en[N], e_addr[N], e_en_tf[N], e_cal[N], e_layer[N];
  int e_busy[N], e_acc[N], e_done[N], e_cyc[N], e_stl[N];

  task automatic check(string name, int c, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  function automatic void put(int c, int cal, int layer, int addr, int done);
    e_cal[c]   = cal;
    e_busy[c]  = 1;
    e_layer[c] = layer;
    e_addr[c]  = addr;
    e_done[c]  = done;
    e_rd_en[c] = 0;
    e_acc[c]   = 0;
  endfunction

  // Lay out one job accepted at edge s: LOAD, K issued beats (stall cycles add a cycle each), DRAIN, DONE.
  function automatic void plan(int s, int layer, int k);
    int c, beats, done_c, cnt_c, cnt_s;
    c = s + 1;
    if (k != 0) begin
      put(c, 1, layer, 0, 0);
      c++;
      beats = 0;
      while (beats < k) begin
        put(c, 2, layer, beats, 0);
        if (!st_stall[c]) begin
          e_rd_en[c] = 1;
          beats++;
        end
        c++;
      end
      for (int i = 0; i < DRAIN; i++) begin
        put(c, 3, layer, k - 1, 0);
        c++;
      end
    end
    done_c = c;
    put(c, 3, layer, (k == 0) ? 0 : k - 1, 1);
    e_acc[c] = (k != 0) ? 1 : 0;
    for (int x = s + 1; x <= done_c; x++)
      e_en_tf[x] = (e_cal[x] == 3 && x != done_c) ? 1 : e_rd_en[x-1];
    cnt_c = 0;
    cnt_s = 0;
    for (int x = s + 1; x < N; x++) begin
      e_cyc[x] = cnt_c;
      e_stl[x] = cnt_s;
      if (x <= done_c) cnt_c++;
      if (x <= done_c && e_cal[x] == 2 && st_stall[x]) cnt_s++;
    end
  endfunction

  // Reset during cycle c: everything is zero from that cycle on.
  function automatic void abort(int c);
    for (int x = c; x < N; x++) begin
      e_rd_en[x] = 0; e_addr[x] = 0; e_en_tf[x] = 0; e_cal[x] = 0; e_layer[x] = 0;
      e_busy[x] = 0;  e_acc[x] = 0;  e_done[x] = 0;  e_cyc[x] = 0; e_stl[x] = 0;
    end
  endfunction

  function automatic void sched(int c, int layer, int k);
    st_start[c] = 1'b1;
    st_layer[c] = layer;
    st_klen[c]  = k;
  endfunction

  // per-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (running) begin
      check("rd_en",       cyc, int'(bus.o_rd_en),       e_rd_en[cyc]);
      check("rd_addr",     cyc, int'(bus.o_rd_addr),     e_addr[cyc]);
      check("en_tf",       cyc, int'(bus.o_en_tf),       e_en_tf[cyc]);
      check("cal_state",   cyc, int'(bus.o_cal_state),   e_cal[cyc]);
      check("layer_state", cyc, int'(bus.o_layer_state), e_layer[cyc]);
      check("busy",        cyc, int'(bus.o_busy),        e_busy[cyc]);
      check("acc_valid",   cyc, int'(bus.o_acc_valid),   e_acc[cyc]);
      check("done",        cyc, int'(bus.o_done),        e_done[cyc]);
`ifdef TILE_CTRL_PERF_EN
      check("cyc_cnt",     cyc, int'(bus.o_cyc_cnt),     e_cyc[cyc]);
      check("stall_cnt",   cyc, int'(bus.o_stall_cnt),   e_stl[cyc]);
`endif
    end
  end

  initial begin
    for (int c = 0; c < N; c++) begin
      st_start[c] = 1'b0;
      st_layer[c] = $urandom_range(0, 7);
      st_klen[c]  = $urandom_range(0, 1023);
      st_stall[c] = 1'b0;
    end
    abort(0);

    // job schedule
    sched(10, 3, 4);                            // basic run, done at 64
    sched(30, 5, 9);                            // start during DRAIN: ignored
    sched(65, 6, 2);                            // back-to-back start, done at 117
    st_stall[100] = 1'b1;                       // stall during DRAIN: ignored
    sched(130, 1, 0);                           // zero length, done at 131
    sched(140, 2, 6);                           // stalled run, done at 199
    for (int c = 144; c <= 146; c++) st_stall[c] = 1'b1;
    sched(210, 4, 5);                           // aborted by reset at 214 (addr 2)
    sched(220, 7, 3);                           // run after reset, done at 273
    st_stall[221] = 1'b1;                       // stall in LOAD: ignored
    for (int c = 230; c <= 232; c++) st_stall[c] = 1'b1;

    plan(10, 3, 4);
    plan(65, 6, 2);
    plan(130, 1, 0);
    plan(140, 2, 6);
    plan(210, 4, 5);
    abort(214);
    plan(220, 7, 3);

    // hand-computed points that pin the planner
    check("pin_done_basic",   64,  e_done[64],   1);
    check("pin_acc_basic",    64,  e_acc[64],    1);
    check("pin_addr3",        15,  e_addr[15],   3);
    check("pin_entf_first",   13,  e_en_tf[13],  1);
    check("pin_entf_pre",     12,  e_en_tf[12],  0);
    check("pin_entf_last",    63,  e_en_tf[63],  1);
    check("pin_busy_after",   65,  e_busy[65],   0);
    check("pin_done_b2b",     117, e_done[117],  1);
    check("pin_done_zero",    131, e_done[131],  1);
    check("pin_acc_zero",     131, e_acc[131],   0);
    check("pin_entf_stall",   145, e_en_tf[145], 0);
    check("pin_entf_resume",  148, e_en_tf[148], 1);
    check("pin_done_stall",   199, e_done[199],  1);
    check("pin_cyc_stall",    200, e_cyc[200],   59);
    check("pin_stl_stall",    200, e_stl[200],   3);
    check("pin_reset_addr",   213, e_addr[213],  1);
    check("pin_done_after",   273, e_done[273],  1);

    bus.i_start = 1'b0;
    bus.i_layer = 3'd0;
    bus.i_k_len = '0;
    bus.i_stall = 1'b0;
    running = 1'b1;
    for (int c = 0; c < N; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      cyc = c;
      bus.i_start = st_start[c];
      bus.i_layer = 3'(st_layer[c]);
      bus.i_k_len = K_BW'(st_klen[c]);
      bus.i_stall = st_stall[c];
      if (c == 2 || c == 216) begin
        #1 rst_n = 1'b1;
      end
      if (c == 214) begin
        #1 rst_n = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tile_array_ctrl.md
Name: tile_array_ctrl

Overview:
- Sequencer for the T_ROWS x T_COLS tile array. It drives the array's transfer-enable, calculation-state and layer-state controls.
- Generates read strobes and addresses for the fmap and weight staging buffers feeding the array edges.
- After the pipeline drains, flags when o_acc_kernel is valid.
- Sits between the layer scheduler (start/done handshake) and the tile array plus its input buffers.

Parameters:
- ROWS, 5, PE rows per tile
- COLS, 5, PE columns per tile
- T_ROWS, 5, tile rows in array
- T_COLS, 5, tile columns in array
- K_BW, 10, width of reduction-length field and read address
- DRAIN_CYC (localparam), ROWS*T_ROWS + COLS*T_COLS - 2 = 48 at defaults, cycles to flush the skewed array

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start request, sampled only in IDLE
- i_layer  in  3  layer code, latched at start and driven to o_layer_state
- i_k_len  in  K_BW  number of input beats (reduction length), latched at start
- i_stall  in  1  staging buffers not ready; honoured only in CALC
- o_rd_en  out  1  buffer read strobe; buffers return data 1 cycle later
- o_rd_addr  out  K_BW  buffer read address
- o_en_tf  out  1  tile array transfer enable
- o_cal_state  out  2  00 IDLE, 01 LOAD, 10 CALC, 11 DRAIN/DONE
- o_layer_state  out  3  latched layer code
- o_busy  out  1  high from LOAD through DONE inclusive
- o_acc_valid  out  1  1-cycle pulse: o_acc_kernel of array valid
- o_done  out  1  1-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - all outputs 0, including o_rd_addr, o_layer_state, internal beat counter and drain counter
  - reset mid-operation aborts immediately; no done/acc_valid pulse is issued.
- FSM states: IDLE, LOAD, CALC, DRAIN, DONE.
- IDLE:
  - outputs 0
  - on i_start=1, latch i_layer and i_k_len
  - if i_k_len==0, go to DONE; else go to LOAD.
- LOAD:
  - exactly 1 cycle
  - o_cal_state=01 (array clears accumulators), o_en_tf=0, o_rd_addr=0
  - go to CALC.
- CALC:
  - o_rd_en = ~i_stall (combinational)
  - o_rd_addr increments by 1 on each cycle with o_rd_en=1, starting at 0
  - beat counter increments on each o_rd_en
  - when the K-th beat issues (addr K-1), go to DRAIN next cycle
  - o_en_tf is a register equal to o_rd_en of the previous cycle, aligned with buffer data arrival.
- DRAIN:
  - o_rd_en=0; o_en_tf=1 every cycle; o_cal_state=11; i_stall ignored
  - counter runs DRAIN_CYC cycles, then go to DONE.
- DONE:
  - 1 cycle; o_done=1
  - o_acc_valid=1 only if latched k_len!=0
  - o_en_tf=0, o_cal_state=11
  - go to IDLE; a new start is accepted the following cycle.
- i_start while not IDLE: ignored, no queuing.
- Changes on i_layer or i_k_len after start: no effect until the next start.
- Timing, no stalls, start sampled at edge 0:
  - LOAD in cycle 1
  - CALC in cycles 2..K+1
  - DRAIN in cycles K+2..K+1+DRAIN_CYC
  - DONE in cycle K+2+DRAIN_CYC
  - each stall cycle in CALC adds exactly 1 cycle.
- o_rd_addr never exceeds K-1; it holds its final value through DRAIN and returns to 0 in IDLE.

Optional Feature:
- Macro TILE_CTRL_PERF_EN.
- Defined:
  - adds outputs o_cyc_cnt (16 bit) and o_stall_cnt (16 bit)
  - both cleared on start acceptance
  - o_cyc_cnt counts every o_busy cycle; o_stall_cnt counts CALC cycles with i_stall=1
  - both saturate at 16'hFFFF and hold their values after DONE until the next start
  - reset to 0.
- Undefined: ports and logic are absent; the remaining behaviour is identical.

Test Plan:
- Basic run: start, i_layer=3, i_k_len=4, no stall:
  - o_rd_addr 0,1,2,3 in cycles 2..5
  - o_en_tf high cycles 3..53
  - o_done and o_acc_valid in cycle 54
  - o_layer_state=3 throughout
  - o_busy high cycles 1..54.
- Zero length: start with i_k_len=0:
  - o_done in cycle 1, o_acc_valid=0
  - o_rd_en never high, o_busy high only in cycle 1.
- Stall: i_k_len=6, i_stall=1 for 3 cycles after the second beat:
  - addresses 0..5 each issued exactly once
  - o_en_tf low for the 3 cycles following the stalled reads
  - o_done in cycle 59; with TILE_CTRL_PERF_EN, o_stall_cnt=3 and o_cyc_cnt=59.
- Start while busy: pulse i_start with i_k_len=9 during DRAIN of a K=4 run:
  - ignored, done still at cycle 54
  - a new start in cycle 55 runs with freshly latched values.
- Async reset: assert rst_n=0 mid-CALC (addr=2):
  - all outputs 0 immediately, without waiting for a clock edge
  - after release, state is IDLE with no o_done
  - the next start runs normally from addr 0.
